// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: word width, register address width and count.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] regAddr_t;

endpackage

// File: rtl/regfile_wr_decoder.sv
// Turns rd/RegWrite into a one-hot write-enable vector; x0 is never enabled.
module regfile_wr_decoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = NUM_REGS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             RegWrite,
  input  logic [AW-1:0]    rd,
  output logic [DEPTH-1:0] wrEn
);

  // RegWrite gates each bit first, so an unknown rd with RegWrite=0 stays inert
  always_comb begin
    wrEn = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wrEn[i] = RegWrite && (rd == AW'(i));
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write integer register file with hard-wired zero x0.
// Define REGFILE_BYPASS_EN to forward WriteData to a read port addressing rd.
module register_file
  import riscv_pkg::*;
#(
  parameter int N     = XLEN,
  parameter int DEPTH = NUM_REGS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWrite,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic [N-1:0]  WriteData,
  output logic [N-1:0]  ReadData1,
  output logic [N-1:0]  ReadData2
);

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] wrEn;

  regfile_wr_decoder #(.DEPTH(DEPTH)) uWrDecoder (
    .RegWrite (RegWrite),
    .rd       (rd),
    .wrEn     (wrEn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wrEn[i]) regs[i] <= WriteData;
      end
    end
  end

  // Zero and reset forcing is applied last so it overrides any forwarded value
  always_comb begin
    ReadData1 = regs[rs1];
    ReadData2 = regs[rs2];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (rd != AW'(ZERO_REG)) && (rs1 == rd)) ReadData1 = WriteData;
    if (RegWrite && (rd != AW'(ZERO_REG)) && (rs2 == rd)) ReadData2 = WriteData;
`else
`endif
    if (rst || (rs1 == AW'(ZERO_REG))) ReadData1 = '0;
    if (rst || (rs2 == AW'(ZERO_REG))) ReadData2 = '0;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 32: data width of every register and data port.
REQ-002 Parameter DEPTH, default 32: number of architectural registers; address width is log2(DEPTH) = 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 RegWrite  input  1  write enable for the current cycle.
REQ-006 rs1  input  5  read address, port 1, drives ALU operand A.
REQ-007 rs2  input  5  read address, port 2, drives ALU operand B (before the immediate mux).
REQ-008 rd  input  5  write address.
REQ-009 WriteData  input  N  write-back value: ALU out, load data or PC+4.
REQ-010 ReadData1  output  N  contents of register rs1.
REQ-011 ReadData2  output  N  contents of register rs2.

Function
REQ-012 Storage SHALL be DEPTH registers of N bits, x0..x31.
REQ-013 Reads SHALL be combinational, zero-cycle latency from rs1/rs2 to ReadData1/ReadData2.
REQ-014 Register x0 SHALL always read 0, on both ports, regardless of any prior write.
REQ-015 On a rising clk with RegWrite=1 and rd!=0, register[rd] SHALL take WriteData.
REQ-016 A write with rd=0 SHALL be discarded with no side effect.
REQ-017 With RegWrite=0, no register SHALL change.
REQ-018 rs1==rs2 SHALL return identical data on both ports.
REQ-019 Same-cycle read of rd while writing rd: without the bypass (REQ-024), the read SHALL return the old value until the edge and the new value after it.
REQ-020 X/unknown on rd while RegWrite=0 SHALL NOT corrupt any register.

Reset
REQ-021 Assertion of rst SHALL clear all registers to 0 immediately, independent of clk.
REQ-022 While rst=1, writes SHALL be ignored and both read ports SHALL return 0.
REQ-023 Release of rst mid-cycle SHALL NOT trigger a write; the first write SHALL occur at the first rising clk after deassertion with RegWrite=1.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN defined: when RegWrite=1, rd!=0 and rsX==rd, ReadDataX SHALL return WriteData combinationally (write-through). The x0 rule still takes precedence.
REQ-025 Macro REGFILE_BYPASS_EN undefined: no forwarding path; behaviour is exactly REQ-019.

Structure
REQ-026 Shared package riscv_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the constant ZERO_REG=5'd0; the width parameters default from it.
REQ-027 One sub-module, regfile_wr_decoder, SHALL convert rd and RegWrite into a DEPTH-bit one-hot write-enable vector with bit 0 forced to 0.
REQ-028 Storage and the read muxes SHALL stay in register_file; no other sub-modules.

Verification
REQ-029 Pulse rst, then read all 32 addresses on both ports -> every read is 0x00000000.
REQ-030 Write x5=0xDEADBEEF (RegWrite=1, rd=5), then rs1=5, rs2=5 -> both ports read 0xDEADBEEF.
REQ-031 Write x0=0xFFFFFFFF, then rs1=0 -> reads 0x00000000.
REQ-032 RegWrite=0 with rd=7 and WriteData=0x12345678, then rs2=7 -> reads the prior value 0.
REQ-033 Hold x3=0x11; in one cycle write x3=0x22 with rs1=3 -> before the edge, reads 0x11 (bypass off) or 0x22 (bypass on); after the edge, reads 0x22 in both builds.
REQ-034 Write x9=0xA5A5A5A5, assert rst asynchronously between clk edges -> ReadData for x9 drops to 0 before the next edge, and the write in the rst-release cycle is not taken.
